// File: rtl/rtc_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_time_set_ctrl
//
// Time-of-day register bank and set-mode sequencer for the Basys3 RTC.
// In RUN the clock advances HH:MM:SS once per tick_1hz. Each btn_mode pulse
// walks the user through SET_HR -> SET_MIN -> SET_SEC -> RUN. While in a SET
// state the time is frozen, btn_up / btn_down adjust only the selected field
// (with wrap and no carry), and the selected digit pair blinks at 0.5 Hz.
// If no button is pressed for TIMEOUT_S ticks in a SET state, the block falls
// back to RUN and keeps the edited values.
//
// Parameters:
//   TIMEOUT_S   idle ticks in a SET state before auto-return to RUN (1..63)
//
// Ports:
//   clk_in      system clock (100 MHz)
//   rst         synchronous, active-high reset
//   tick_1hz    single-cycle strobe, once per second
//   btn_mode    debounced single-cycle pulse: advance edit field
//   btn_up      debounced single-cycle pulse: increment selected field
//   btn_down    debounced single-cycle pulse: decrement selected field
//   hours       current hours, 0..23
//   minutes     current minutes, 0..59
//   seconds     current seconds, 0..59
//   edit_field  0 = none (RUN), 1 = hours, 2 = minutes, 3 = seconds
//   blink       flash enable for the selected field; 0 in RUN
//
// Every output comes straight from a flop, so each output changes on the
// clk_in edge that samples the causing input.
// -----------------------------------------------------------------------------
module rtc_time_set_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] edit_field,
    output logic       blink
);

    // The state encoding doubles as the edit_field code.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam logic [5:0] HOURS_MAX = 6'd23;
    localparam logic [5:0] MS_MAX    = 6'd59;
    // The timeout fires on the tick that would take the counter to TIMEOUT_S.
    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

    state_t     state_q,   state_d;
    logic [4:0] hours_q,   hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q,   blink_d;
    logic [5:0] idle_q,    idle_d;

    // -------------------------------------------------------------------------
    // Wrapping field arithmetic. Out-of-range inputs cannot occur, but they
    // are folded back into range anyway so a field can never leave 0..max.
    // -------------------------------------------------------------------------
    function automatic logic [5:0] wrap_inc(input logic [5:0] val,
                                            input logic [5:0] max);
        return (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] val,
                                            input logic [5:0] max);
        return (val == 6'd0 || val > max) ? max : val - 6'd1;
    endfunction

    // Next state in the mode cycle RUN -> HR -> MIN -> SEC -> RUN.
    function automatic state_t next_mode(input state_t cur);
        state_t nxt;
        case (cur)
            ST_RUN:     nxt = ST_SET_HR;
            ST_SET_HR:  nxt = ST_SET_MIN;
            ST_SET_MIN: nxt = ST_SET_SEC;
            default:    nxt = ST_RUN;
        endcase
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Run-mode time advance, computed unconditionally and used only when
    // the FSM is in RUN and a tick arrives.
    // -------------------------------------------------------------------------
    logic       sec_wrap;
    logic       min_wrap;
    logic [4:0] hours_adv;
    logic [5:0] minutes_adv;
    logic [5:0] seconds_adv;

    always_comb begin
        sec_wrap    = (seconds_q >= MS_MAX);
        min_wrap    = (minutes_q >= MS_MAX);
        seconds_adv = wrap_inc(seconds_q, MS_MAX);
        minutes_adv = minutes_q;
        hours_adv   = hours_q;
        if (sec_wrap) begin
            minutes_adv = wrap_inc(minutes_q, MS_MAX);
            if (min_wrap) begin
                hours_adv = 5'(wrap_inc({1'b0, hours_q}, HOURS_MAX));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Set-mode field adjust. Up and down together cancel; only the field
    // selected by the current state moves.
    // -------------------------------------------------------------------------
    logic       adj_up;
    logic       adj_down;
    logic [4:0] hours_adj;
    logic [5:0] minutes_adj;
    logic [5:0] seconds_adj;

    always_comb begin
        adj_up      = btn_up & ~btn_down;
        adj_down    = btn_down & ~btn_up;
        hours_adj   = hours_q;
        minutes_adj = minutes_q;
        seconds_adj = seconds_q;
        case (state_q)
            ST_SET_HR: begin
                if (adj_up)   hours_adj = 5'(wrap_inc({1'b0, hours_q}, HOURS_MAX));
                if (adj_down) hours_adj = 5'(wrap_dec({1'b0, hours_q}, HOURS_MAX));
            end
            ST_SET_MIN: begin
                if (adj_up)   minutes_adj = wrap_inc(minutes_q, MS_MAX);
                if (adj_down) minutes_adj = wrap_dec(minutes_q, MS_MAX);
            end
            ST_SET_SEC: begin
                if (adj_up)   seconds_adj = wrap_inc(seconds_q, MS_MAX);
                if (adj_down) seconds_adj = wrap_dec(seconds_q, MS_MAX);
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / next-output logic.
    // Priority inside a SET state: btn_mode, then up/down, then tick timeout.
    // A tick in the same cycle as up/down still toggles blink, but cannot
    // time out because the button clears the idle counter.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through the
        // case/if tree leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;
        idle_d    = idle_q;

        if (state_q == ST_RUN) begin
            blink_d = 1'b0;
            idle_d  = 6'd0;
            // A tick coinciding with btn_mode still advances time, since it
            // is sampled with the RUN state.
            if (tick_1hz) begin
                hours_d   = hours_adv;
                minutes_d = minutes_adv;
                seconds_d = seconds_adv;
            end
            if (btn_mode) begin
                state_d = ST_SET_HR;
                blink_d = 1'b1;
            end
        end else if (btn_mode) begin
            // Up/down in the same cycle is discarded.
            state_d = next_mode(state_q);
            idle_d  = 6'd0;
            blink_d = (next_mode(state_q) != ST_RUN);
        end else if (btn_up || btn_down) begin
            hours_d   = hours_adj;
            minutes_d = minutes_adj;
            seconds_d = seconds_adj;
            idle_d    = 6'd0;
            if (tick_1hz) begin
                blink_d = ~blink_q;
            end
        end else if (tick_1hz) begin
            if (idle_q >= IDLE_LAST) begin
                state_d = ST_RUN;
                blink_d = 1'b0;
                idle_d  = 6'd0;
            end else begin
                idle_d  = idle_q + 6'd1;
                blink_d = ~blink_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_RUN;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
            blink_q   <= 1'b0;
            idle_q    <= 6'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            blink_q   <= blink_d;
            idle_q    <= idle_d;
        end
    end

    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule
